// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the sequential ALU.
package alu_pkg;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_OUT  = 3'd4
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: MIPS-funct opcodes, carry/overflow for ADD/SUB,
// saturating shift amounts, error flag on unsupported opcodes.
module alu_core
  import alu_pkg::*;
#(
  parameter int NB_DATA = 6,
  parameter int NB_OP   = 6
) (
  input  logic [NB_DATA-1:0] a,
  input  logic [NB_DATA-1:0] b,
  input  logic [NB_OP-1:0]   op,
  output logic [NB_DATA-1:0] result,
  output logic               carry,
  output logic               ovf,
  output logic               err
);

  localparam logic [NB_DATA-1:0] SH_LIMIT = NB_DATA'(NB_DATA);

  logic [NB_DATA:0] sum;
  logic [NB_DATA:0] diff;
  logic             shift_big;

  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    diff      = {1'b0, a} - {1'b0, b};
    shift_big = (b >= SH_LIMIT);
    result    = '0;
    carry     = 1'b0;
    ovf       = 1'b0;
    err       = 1'b0;
    case (op)
      NB_OP'(OP_ADD): begin
        result = sum[NB_DATA-1:0];
        carry  = sum[NB_DATA];
        ovf    = (a[NB_DATA-1] == b[NB_DATA-1]) && (sum[NB_DATA-1] != a[NB_DATA-1]);
      end
      // Borrow out of the extended subtraction means A < B, so carry is its inverse.
      NB_OP'(OP_SUB): begin
        result = diff[NB_DATA-1:0];
        carry  = ~diff[NB_DATA];
        ovf    = (a[NB_DATA-1] != b[NB_DATA-1]) && (diff[NB_DATA-1] != a[NB_DATA-1]);
      end
      NB_OP'(OP_AND): result = a & b;
      NB_OP'(OP_OR):  result = a | b;
      NB_OP'(OP_XOR): result = a ^ b;
      NB_OP'(OP_NOR): result = ~(a | b);
      NB_OP'(OP_SRL): result = shift_big ? '0 : (a >> b);
      NB_OP'(OP_SRA): result = shift_big ? {NB_DATA{a[NB_DATA-1]}}
                                         : $unsigned($signed(a) >>> b);
      default:        err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Button-driven sequential ALU: loads A, B and opcode from one switch bus,
// executes once and presents the result behind a valid/ready handshake.
module alu_seq
  import alu_pkg::*;
#(
  parameter int NB_DATA = 6,
  parameter int NB_OP   = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NB_DATA-1:0] i_sw,
  input  logic               i_btn_a,
  input  logic               i_btn_b,
  input  logic               i_btn_op,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_zero,
  output logic               o_neg,
  output logic               o_carry,
  output logic               o_ovf,
  output logic               o_err,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [2:0]         o_state
);

  state_t state, state_next;

  logic [2:0] btn_sync, btn_prev, pulse;
  logic [NB_DATA-1:0] a_reg, b_reg;
  logic [NB_OP-1:0]   op_reg;
  logic ld_a, ld_b, ld_op, exec;

  logic [NB_DATA-1:0] core_result;
  logic core_carry, core_ovf, core_err;

  // Buttons are registered once; a pulse is the registered level rising.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_sync <= '0;
      btn_prev <= '0;
    end else begin
      btn_sync <= {i_btn_op, i_btn_b, i_btn_a};
      btn_prev <= btn_sync;
    end
  end

  assign pulse = btn_sync & ~btn_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_A;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_A:     if (pulse[0]) state_next = S_B;
      S_B:     if (pulse[1]) state_next = S_OP;
      S_OP:    if (pulse[2]) state_next = S_EXEC;
      S_EXEC:  state_next = S_OUT;
      S_OUT:   if (o_valid && i_ready) state_next = S_A;
      default: state_next = S_A;
    endcase
  end

  always_comb begin
    ld_a    = (state == S_A)  && pulse[0];
    ld_b    = (state == S_B)  && pulse[1];
    ld_op   = (state == S_OP) && pulse[2];
    exec    = (state == S_EXEC);
    o_state = state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg  <= '0;
      b_reg  <= '0;
      op_reg <= '0;
    end else begin
      if (ld_a)  a_reg  <= i_sw;
      if (ld_b)  b_reg  <= i_sw;
      if (ld_op) op_reg <= i_sw[NB_OP-1:0];
    end
  end

  alu_core #(
    .NB_DATA(NB_DATA),
    .NB_OP  (NB_OP)
  ) u_core (
    .a     (a_reg),
    .b     (b_reg),
    .op    (op_reg),
    .result(core_result),
    .carry (core_carry),
    .ovf   (core_ovf),
    .err   (core_err)
  );

  // Result and flags only change in S_EXEC; valid drops the cycle after acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_result <= '0;
      o_zero   <= 1'b0;
      o_neg    <= 1'b0;
      o_carry  <= 1'b0;
      o_ovf    <= 1'b0;
      o_err    <= 1'b0;
      o_valid  <= 1'b0;
    end else if (exec) begin
      o_result <= core_result;
      o_zero   <= (core_result == '0);
      o_neg    <= core_result[NB_DATA-1];
      o_carry  <= core_carry;
      o_ovf    <= core_ovf;
      o_err    <= core_err;
      o_valid  <= 1'b1;
    end else if (o_valid && i_ready) begin
      o_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, handshake/reset
// sequences and randomized operations against an integer reference model.
module tb_alu_seq;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] i_sw;
  logic       i_btn_a, i_btn_b, i_btn_op, i_ready;
  logic [5:0] o_result;
  logic       o_zero, o_neg, o_carry, o_ovf, o_err, o_valid;
  logic [2:0] o_state;

  int checks = 0;
  int errors = 0;

  // flags packed as {zero, neg, carry, ovf, err}
  typedef struct packed {
    logic [5:0] a;
    logic [5:0] b;
    logic [5:0] op;
    logic [5:0] res;
    logic [4:0] flags;
  } vec_t;

  vec_t tbl[14];
  logic [5:0] ops[8];

  always #5 clk = ~clk;

  alu_seq #(.NB_DATA(6), .NB_OP(6)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_sw    (i_sw),
    .i_btn_a (i_btn_a),
    .i_btn_b (i_btn_b),
    .i_btn_op(i_btn_op),
    .o_result(o_result),
    .o_zero  (o_zero),
    .o_neg   (o_neg),
    .o_carry (o_carry),
    .o_ovf   (o_ovf),
    .o_err   (o_err),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_state (o_state)
  );

  // Reference model in plain integer arithmetic; returns {result, flags}.
  function automatic logic [10:0] model(input int a, input int b, input int op);
    int sa, sb, v, sh, p;
    logic c, ov, e;
    sa = (a >= 32) ? a - 64 : a;
    sb = (b >= 32) ? b - 64 : b;
    c = 1'b0; ov = 1'b0; e = 1'b0; v = 0;
    case (op)
      32: begin v = (a + b) % 64; c = (a + b) >= 64; ov = (sa + sb > 31) || (sa + sb < -32); end
      34: begin v = (a - b + 64) % 64; c = (a >= b); ov = (sa - sb > 31) || (sa - sb < -32); end
      36: v = a & b;
      37: v = a | b;
      38: v = a ^ b;
      39: v = 63 - (a | b);
      2:  v = (b >= 6) ? 0 : a / (1 << b);
      3: begin
        sh = (b >= 6) ? 6 : b;
        p  = 1 << sh;
        v  = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
        v  = (v + 64) % 64;
      end
      default: e = 1'b1;
    endcase
    return {6'(v), (v == 0), (v >= 32), c, ov, e};
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic waitState(input logic [2:0] s, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (o_state == s) ok = 1'b1;
    end
    checkOutput(name, int'(ok), 1);
  endtask

  task automatic setBtn(input int which, input logic v);
    case (which)
      0: i_btn_a = v;
      1: i_btn_b = v;
      default: i_btn_op = v;
    endcase
  endtask

  task automatic pressLoad(input int which, input logic [5:0] val, input logic [2:0] target,
                           input string name);
    i_sw = val;
    setBtn(which, 1'b1);
    waitState(target, name);
    setBtn(which, 1'b0);
    i_sw = 6'($urandom);
    @(negedge clk);
    @(negedge clk);
  endtask

  // Runs one full load/execute/handshake and returns what the DUT presented.
  task automatic applyStimulus(input logic [5:0] a, input logic [5:0] b, input logic [5:0] op,
                               input bit ready_early, output logic [10:0] got);
    logic [10:0] held;
    i_ready = ready_early;
    pressLoad(0, a, S_B, "accept_a");
    pressLoad(1, b, S_OP, "accept_b");
    i_sw = op;
    i_btn_op = 1'b1;
    waitState(S_EXEC, "accept_op");
    i_sw = 6'($urandom);
    checkOutput("valid_low_in_exec", int'(o_valid), 0);
    @(negedge clk);
    checkOutput("valid_latency", int'(o_valid), 1);
    checkOutput("state_out", int'(o_state), int'(S_OUT));
    got = {o_result, o_zero, o_neg, o_carry, o_ovf, o_err};
    i_btn_op = 1'b0;
    if (!ready_early) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        held = {o_result, o_zero, o_neg, o_carry, o_ovf, o_err};
        checkOutput("hold_valid", int'(o_valid), 1);
        checkOutput("hold_outputs", int'(held), int'(got));
      end
      i_ready = 1'b1;
    end
    @(negedge clk);
    checkOutput("valid_drop", int'(o_valid), 0);
    checkOutput("back_to_a", int'(o_state), int'(S_A));
    checkOutput("result_kept", int'(o_result), int'(got[10:5]));
    i_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [10:0] got, exp;
    logic [5:0] ra, rb, rop;
    ops = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
            6'b100110, 6'b100111, 6'b000011, 6'b000010};
    tbl[0]  = '{6'd15, 6'd20, 6'b100000, 6'd35, 5'b01010};
    tbl[1]  = '{6'd20, 6'd15, 6'b100010, 6'd5,  5'b00100};
    tbl[2]  = '{6'd15, 6'd20, 6'b100100, 6'd4,  5'b00000};
    tbl[3]  = '{6'd15, 6'd20, 6'b100101, 6'd31, 5'b00000};
    tbl[4]  = '{6'd15, 6'd20, 6'b100110, 6'd27, 5'b00000};
    tbl[5]  = '{6'd15, 6'd20, 6'b100111, 6'd32, 5'b01000};
    tbl[6]  = '{6'd20, 6'd3,  6'b000011, 6'd2,  5'b00000};
    tbl[7]  = '{6'b111000, 6'd2, 6'b000011, 6'b111110, 5'b01000};
    tbl[8]  = '{6'd15, 6'd3,  6'b000010, 6'd1,  5'b00000};
    tbl[9]  = '{6'd15, 6'd9,  6'b000010, 6'd0,  5'b10000};
    tbl[10] = '{6'b100000, 6'd9, 6'b000011, 6'b111111, 5'b01000};
    tbl[11] = '{6'd15, 6'd20, 6'b111111, 6'd0,  5'b10001};
    tbl[12] = '{6'd15, 6'd20, 6'b100010, 6'd59, 5'b01000};
    tbl[13] = '{6'd40, 6'd40, 6'b100000, 6'd16, 5'b00110};

    reset = 1'b1; i_sw = '0; i_btn_a = 0; i_btn_b = 0; i_btn_op = 0; i_ready = 0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_outputs", int'({o_result, o_zero, o_neg, o_carry, o_ovf, o_err, o_valid}), 0);
    checkOutput("reset_state", int'(o_state), int'(S_A));
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(tbl[i].a, tbl[i].b, tbl[i].op, 1'b1, got);
      checkOutput($sformatf("vec%0d_result", i), int'(got[10:5]), int'(tbl[i].res));
      checkOutput($sformatf("vec%0d_flags", i), int'(got[4:0]), int'(tbl[i].flags));
    end

    // Consumer stalls for 10 cycles before accepting.
    applyStimulus(6'd20, 6'd15, 6'b100010, 1'b0, got);
    checkOutput("stall_result", int'(got), int'({6'd5, 5'b00100}));

    // Out-of-order buttons in S_A must be ignored and must not queue.
    i_btn_b = 1'b1; i_btn_op = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("ignore_b_op", int'(o_state), int'(S_A));
    i_btn_b = 1'b0; i_btn_op = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus(6'd7, 6'd9, 6'b100000, 1'b1, got);
    checkOutput("after_ignore", int'(got), int'(model(7, 9, 32)));

    // Reset while parked in S_OP with nonzero outputs still held.
    applyStimulus(6'd15, 6'd20, 6'b100000, 1'b1, got);
    pressLoad(0, 6'd33, S_B, "rst_seq_a");
    pressLoad(1, 6'd12, S_OP, "rst_seq_b");
    reset = 1'b1;
    #1;
    checkOutput("midreset_outputs", int'({o_result, o_zero, o_neg, o_carry, o_ovf, o_err, o_valid}), 0);
    checkOutput("midreset_state", int'(o_state), int'(S_A));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    applyStimulus(6'd33, 6'd12, 6'b100110, 1'b1, got);
    checkOutput("post_reset_op", int'(got), int'(model(33, 12, 38)));

    for (int i = 0; i < 25; i++) begin
      ra  = 6'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 10)) : 6'($urandom);
      rop = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
      exp = model(int'(ra), int'(rb), int'(rop));
      applyStimulus(ra, rb, rop, 1'($urandom_range(0, 1)), got);
      checkOutput($sformatf("rand%0d a=%0d b=%0d op=%0d", i, ra, rb, rop), int'(got), int'(exp));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
